fp16_pack4: RTL and testbench
=============================

Name: fp16_pack4

Overview:
- Streaming packer directly downstream of the FP64-to-FP16 converter.
- Accepts one FP16 result per beat over a valid/ready handshake and packs four results into one 64-bit word for the 64-bit writeback/store path.
- Supports early word termination via in_last, with a lane-keep mask.
- Reports per-word sticky NaN/Inf flags so software can detect conversion exceptions without unpacking.

Parameters:
- LANES, 4, FP16 lanes per output word (supported value: 4; width of out_keep and lane counter derived from it).
- W, 16, lane width in bits (fixed at 16 for FP16).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream FP16 beat valid.
- in_ready  output  1  packer can accept a beat this cycle.
- in_data  input  16  FP16 value, {sign, exp[4:0], mant[9:0]}.
- in_last  input  1  beat closes the current word (partial word allowed).
- out_valid  output  1  packed word valid.
- out_ready  input  1  downstream accepts word.
- out_data  output  64  packed word; lane k in bits [16k+15:16k].
- out_keep  output  4  bit k set = lane k holds a real value.
- out_has_nan  output  1  any kept lane is NaN (sNaN or qNaN).
- out_has_inf  output  1  any kept lane is ±Inf.

Behaviour:
- Reset (async assert, sync release) clears all state:
  - out_valid=0, out_data=0, out_keep=0, out_has_nan=0, out_has_inf=0.
  - lane counter=0, accumulator=0, sticky flags=0.
- Any partial word in flight at reset is discarded.
- Handshake and ready:
  - Beat accepted when in_valid & in_ready.
  - Word transferred when out_valid & out_ready.
  - in_ready = !out_valid | out_ready, so one beat per cycle at full throughput.
  - in_ready is combinational from out_valid/out_ready only; it never depends on in_valid.
- State:
  - Lane counter cnt (0..3), 64-bit accumulator acc, 4-bit keep accumulator, sticky nan/inf accumulators.
  - Output register set (out_*) acts as a one-entry buffer.
- Accepted beat, not completing (cnt<3 and !in_last):
  - acc lane[cnt] <= in_data; keep[cnt] <= 1; sticky flags OR in the classification of in_data; cnt <= cnt+1.
- Accepted beat, completing (cnt==3 or in_last):
  - Output register loads acc merged with in_data in lane[cnt], keep with bit cnt set, and flags merged with this beat.
  - out_valid <= 1 on the next edge.
  - acc, keep, flags and cnt cleared to 0.
  - Lanes above cnt in out_data are 0; corresponding keep bits are 0.
- Latency: completing beat accepted at edge N gives out_valid=1 at edge N.
  - Visible in the cycle after the accepting cycle, i.e. 1 cycle.
- Simultaneous completing accept and output drain in the same cycle: the new word replaces the old one, and out_valid stays 1.
- Output drain with no completing accept: out_valid <= 0; out_data/out_keep/flags hold their values (don't-care when out_valid=0).
- in_last on the first beat (cnt==0) produces a single-lane word with out_keep=4'b0001.
- No zero-lane words are ever emitted.
- Counter wraps 3→0 only via the completing path; no other wrap exists.
- Output stable while out_valid & !out_ready; upstream is held off by in_ready=0.
  - A non-completing beat is also held off, which keeps the logic simple.
- in_valid=1 with in_ready=0: no state change.
- Classification:
  - NaN: exp==5'h1F and mant!=0.
  - Inf: exp==5'h1F and mant==0.
  - Sign is ignored for both flags.

Decomposition:
- Shared package fp16_pkg:
  - FP16_EXP_MAX=5'h1F, FP16_QNAN=16'h7E00, FP16_POS_INF=16'h7C00, FP16_NEG_INF=16'hFC00.
  - PACK_LANES=4, PACK_CNT_W=2.
- Sub-module: reuse the existing fp_classify with width 16 on in_data.
  - is_snan|is_qnan drives the nan flag; is_pos_inf|is_neg_inf drives the inf flag.
- The remaining logic (counter, accumulator, output buffer) lives in fp16_pack4.

Test Plan:
- Full word, back-to-back: beats 3C00, 4000, 4200, 4400 with out_ready=1.
  - out_data=64'h4400_4200_4000_3C00, out_keep=4'hF, flags 0.
  - out_valid pulses 1 cycle after the 4th beat; in_ready stays 1.
- Early termination: beats 3C00, BC00(in_last).
  - out_data=64'h0000_0000_BC00_3C00, out_keep=4'b0011.
  - Next word starts at lane 0.
- Backpressure: out_ready=0 after the first word is produced; supply 4 more beats.
  - in_ready=0 while out_valid.
  - out_data holds 64'h4400_4200_4000_3C00 unchanged.
  - Raise out_ready: the first word drains, then the second word follows with no beat lost or duplicated.
- Flags: beats 7E01, FC00, 0001, 0000.
  - out_has_nan=1, out_has_inf=1.
  - Next word 3C00×4 has both flags 0 (sticky cleared per word).
- Reset mid-word: 2 beats accepted, then rst_n=0 asynchronously mid-cycle.
  - All outputs 0 immediately.
  - After release, 4 beats produce a word containing only the new values, keep=4'hF.
- Single-lane words: 8 consecutive beats all with in_last=1, out_ready=1.
  - 8 words, each keep=4'b0001.
  - out_valid stays 1 continuously (simultaneous load/drain).

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared FP16 constants and types used by the FP16 conversion and packing path.
package fp16_pkg;

    localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;
    localparam logic [15:0] FP16_QNAN    = 16'h7E00;
    localparam logic [15:0] FP16_POS_INF = 16'h7C00;
    localparam logic [15:0] FP16_NEG_INF = 16'hFC00;

    localparam int PACK_LANES = 4;
    localparam int PACK_CNT_W = 2;

    // Per-word exception summary carried alongside packed data.
    typedef struct packed {
        logic nan;
        logic inf;
    } fp_flags_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 special-value classifier for 16/32/64-bit encodings.
module fp_classify #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    output logic             is_snan,
    output logic             is_qnan,
    output logic             is_pos_inf,
    output logic             is_neg_inf
);

    localparam int EXP_W = (WIDTH == 16) ? 5 : (WIDTH == 32) ? 8 : 11;
    localparam int MAN_W = WIDTH - 1 - EXP_W;

    logic             sign;
    logic [EXP_W-1:0] exponent;
    logic [MAN_W-1:0] mantissa;
    logic             exp_all_ones;
    logic             man_zero;

    assign sign         = value[WIDTH-1];
    assign exponent     = value[WIDTH-2 -: EXP_W];
    assign mantissa     = value[MAN_W-1:0];
    assign exp_all_ones = &exponent;
    assign man_zero     = (mantissa == '0);

    // Quiet NaNs carry the mantissa MSB set; signalling NaNs have it clear.
    assign is_qnan    = exp_all_ones & mantissa[MAN_W-1];
    assign is_snan    = exp_all_ones & !man_zero & !mantissa[MAN_W-1];
    assign is_pos_inf = exp_all_ones & man_zero & !sign;
    assign is_neg_inf = exp_all_ones & man_zero & sign;

endmodule

// File: rtl/fp16_pack4.sv
// Packs a stream of FP16 beats into 64-bit words with lane-keep mask and
// per-word sticky NaN/Inf flags; the output register is a one-entry buffer.
module fp16_pack4
    import fp16_pkg::*;
#(
    parameter int LANES = PACK_LANES,
    parameter int W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_data,
    output logic [LANES-1:0]   out_keep,
    output logic               out_has_nan,
    output logic               out_has_inf
);

    localparam int CNT_W = PACK_CNT_W;

    logic [CNT_W-1:0]   cnt;
    logic [LANES*W-1:0] acc;
    logic [LANES-1:0]   keep_acc;
    fp_flags_t          flags_acc;

    logic               is_snan, is_qnan, is_pos_inf, is_neg_inf;
    fp_flags_t          beat_flags;
    fp_flags_t          merged_flags;
    logic [LANES*W-1:0] merged_data;
    logic [LANES-1:0]   merged_keep;
    logic               accept;
    logic               complete;

    fp_classify #(.WIDTH(W)) u_classify (
        .value      (in_data),
        .is_snan    (is_snan),
        .is_qnan    (is_qnan),
        .is_pos_inf (is_pos_inf),
        .is_neg_inf (is_neg_inf)
    );

    // Depends only on the output buffer, never on in_valid, to avoid a comb loop upstream.
    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign complete = accept & ((cnt == CNT_W'(LANES - 1)) | in_last);

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        merged_data                 = acc;
        merged_data[cnt*W +: W]     = in_data;
        merged_keep                 = keep_acc | (LANES'(1) << cnt);
        beat_flags.nan              = is_snan | is_qnan;
        beat_flags.inf              = is_pos_inf | is_neg_inf;
        merged_flags                = flags_acc | beat_flags;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            acc         <= '0;
            keep_acc    <= '0;
            flags_acc   <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_keep    <= '0;
            out_has_nan <= 1'b0;
            out_has_inf <= 1'b0;
        end else if (complete) begin
            out_valid   <= 1'b1;
            out_data    <= merged_data;
            out_keep    <= merged_keep;
            out_has_nan <= merged_flags.nan;
            out_has_inf <= merged_flags.inf;
            cnt         <= '0;
            acc         <= '0;
            keep_acc    <= '0;
            flags_acc   <= '0;
        end else begin
            if (accept) begin
                acc       <= merged_data;
                keep_acc  <= merged_keep;
                flags_acc <= merged_flags;
                cnt       <= cnt + 1'b1;
            end
            // Payload holds after a drain; only the valid bit drops.
            if (out_valid & out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp16_pack4.sv
// Directed self-checking bench for fp16_pack4 with hand-computed expected words.
module tb_fp16_pack4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_keep;
    logic        out_has_nan;
    logic        out_has_inf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp16_pack4 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_keep    (out_keep),
        .out_has_nan (out_has_nan),
        .out_has_inf (out_has_inf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge; inputs change only there.
    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [15:0] data, input logic last);
        int budget = 0;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        while (!in_ready && budget < 20) begin
            cycle(1);
            budget++;
        end
        if (!in_ready) check("send_timeout", 64'(budget), 64'd0);
        cycle(1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [63:0] data, input logic [3:0] keep,
                              input logic nan, input logic inf);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, out_data, data);
        check({tag, "_keep"}, 64'(out_keep), 64'(keep));
        check({tag, "_nan"}, 64'(out_has_nan), 64'(nan));
        check({tag, "_inf"}, 64'(out_has_inf), 64'(inf));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        cycle(2);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_keep", 64'(out_keep), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        cycle(1);

        // Full word, back-to-back with in_ready continuously high.
        send(16'h3C00, 1'b0);
        check("full_rdy1", 64'(in_ready), 64'd1);
        send(16'h4000, 1'b0);
        send(16'h4200, 1'b0);
        check("full_novalid", 64'(out_valid), 64'd0);
        send(16'h4400, 1'b0);
        check_word("full", 64'h4400_4200_4000_3C00, 4'hF, 1'b0, 1'b0);
        check("full_rdy2", 64'(in_ready), 64'd1);
        idle();
        cycle(1);
        check("full_pulse", 64'(out_valid), 64'd0);

        // Early termination, then next word restarts at lane 0.
        send(16'h3C00, 1'b0);
        send(16'hBC00, 1'b1);
        check_word("early", 64'h0000_0000_BC00_3C00, 4'b0011, 1'b0, 1'b0);
        send(16'h1234, 1'b1);
        check_word("restart", 64'h0000_0000_0000_1234, 4'b0001, 1'b0, 1'b0);
        idle();
        cycle(1);

        // Backpressure: first word held, blocked beat causes no state change.
        out_ready = 1'b0;
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b0);
        send(16'h4200, 1'b0);
        send(16'h4400, 1'b0);
        idle();
        check("bp_rdy", 64'(in_ready), 64'd0);
        cycle(3);
        check_word("bp_hold", 64'h4400_4200_4000_3C00, 4'hF, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h5000;
        in_last  = 1'b0;
        cycle(2);
        check_word("bp_blocked", 64'h4400_4200_4000_3C00, 4'hF, 1'b0, 1'b0);
        out_ready = 1'b1;
        cycle(1);
        check("bp_drain", 64'(out_valid), 64'd0);
        send(16'h5200, 1'b0);
        send(16'h5400, 1'b0);
        send(16'h5600, 1'b0);
        check_word("bp_second", 64'h5600_5400_5200_5000, 4'hF, 1'b0, 1'b0);
        idle();
        cycle(1);

        // Sticky flags, cleared per word.
        send(16'h7E01, 1'b0);
        send(16'hFC00, 1'b0);
        send(16'h0001, 1'b0);
        send(16'h0000, 1'b0);
        check_word("flags", 64'h0000_0001_FC00_7E01, 4'hF, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send(16'h3C00, 1'b0);
        check_word("flags_clr", 64'h3C00_3C00_3C00_3C00, 4'hF, 1'b0, 1'b0);
        send(16'h7C01, 1'b0);
        send(16'h7C00, 1'b1);
        check_word("flags_snan_inf", 64'h0000_0000_7C00_7C01, 4'b0011, 1'b1, 1'b1);
        send(16'h7C00, 1'b1);
        check_word("flags_inf_only", 64'h0000_0000_0000_7C00, 4'b0001, 1'b0, 1'b1);
        idle();
        cycle(1);

        // Asynchronous reset mid-word discards the partial word.
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_data", out_data, 64'd0);
        check("arst_keep", 64'(out_keep), 64'd0);
        check("arst_flags", 64'({out_has_nan, out_has_inf}), 64'd0);
        #3 rst_n = 1'b1;
        @(negedge clk);
        send(16'hA001, 1'b0);
        send(16'hA002, 1'b0);
        send(16'hA003, 1'b0);
        send(16'hA004, 1'b0);
        check_word("arst_new", 64'hA004_A003_A002_A001, 4'hF, 1'b0, 1'b0);
        idle();
        cycle(1);

        // Single-lane words back-to-back: out_valid never drops.
        for (int i = 0; i < 8; i++) begin
            logic [15:0] v;
            v = 16'h0100 * 16'(i + 1) + 16'(i);
            send(v, 1'b1);
            check_word($sformatf("single%0d", i), 64'(v), 4'b0001, 1'b0, 1'b0);
        end
        idle();
        cycle(1);
        check("single_end", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
